// File: rtl/transmissor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : transmissor_pkg
// Description : Shared definitions for the serial frame transmitter:
//               debug state codes, FSM state encoding, default terminator
//               byte and frame length.
//               Optional macro ENVIA_CHECKSUM_EN adds a checksum byte to the
//               frame (5 bytes instead of 4).
// Revision    : 1.0 - initial release
// ============================================================================
package transmissor_pkg;

  // Debug codes published on db_estado; the state encoding reuses them.
  localparam logic [3:0] DB_OCIOSO    = 4'h0;
  localparam logic [3:0] DB_START     = 4'h1;
  localparam logic [3:0] DB_DADOS     = 4'h2;
  localparam logic [3:0] DB_STOP      = 4'h3;
  localparam logic [3:0] DB_PROX_BYTE = 4'h4;
  localparam logic [3:0] DB_FIM       = 4'h5;
  localparam logic [3:0] DB_ERRO      = 4'hF;

  typedef enum logic [3:0] {
    ST_OCIOSO    = DB_OCIOSO,
    ST_START     = DB_START,
    ST_DADOS     = DB_DADOS,
    ST_STOP      = DB_STOP,
    ST_PROX_BYTE = DB_PROX_BYTE,
    ST_FIM       = DB_FIM,
    ST_ERRO      = DB_ERRO
  } estado_t;

  localparam logic [7:0] TERMINADOR_PADRAO = 8'h0A;

`ifdef ENVIA_CHECKSUM_EN
  localparam int BYTES_QUADRO = 5;
`else
  localparam int BYTES_QUADRO = 4;
`endif

  // Width of the byte index inside the frame.
  localparam int IDX_W = $clog2(BYTES_QUADRO);

endpackage
`default_nettype wire

// File: rtl/gerador_tick_baud.sv
`default_nettype none
// ============================================================================
// Module      : gerador_tick_baud
// Description : Bit-period timer. Counts 0..CICLOS_POR_BIT-1 and raises
//               `tick` during the terminal count. `zera` restarts the count
//               synchronously so each state starts a fresh bit period.
// Ports       : clock, reset (sync, active-high), zera (sync clear),
//               tick (terminal-count flag)
// Revision    : 1.0 - initial release
// ============================================================================
module gerador_tick_baud #(
  parameter int CICLOS_POR_BIT = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  output logic tick
);

  localparam int LARGURA = $clog2(CICLOS_POR_BIT);
  localparam logic [LARGURA-1:0] TERMINAL = LARGURA'(CICLOS_POR_BIT - 1);

  logic [LARGURA-1:0] r_contador;

  always_ff @(posedge clock) begin
    if (reset || zera) begin
      r_contador <= '0;
    end else if (r_contador == TERMINAL) begin
      r_contador <= '0;
    end else begin
      r_contador <= r_contador + LARGURA'(1);
    end
  end

  assign tick = (r_contador == TERMINAL);

endmodule
`default_nettype wire

// File: rtl/transmissor_quadro_serial.sv
`default_nettype none
// ============================================================================
// Module      : transmissor_quadro_serial
// Description : Captures screen code and score on envia_dados and sends one
//               fixed frame over a UART line (8N1, LSB first):
//               tela, pontuacao[15:8], pontuacao[7:0], [checksum,] TERMINADOR.
//               Macro ENVIA_CHECKSUM_EN inserts the XOR checksum byte.
// Ports       : clock, reset (sync, active-high)
//               envia_dados      - start request pulse
//               tela_renderizada - screen code, sampled with envia_dados
//               pontuacao        - score, sampled with envia_dados
//               saida_serial     - registered UART TX line, idles high
//               fim_envia_dados  - one-cycle end-of-frame pulse
//               ocupado          - frame in flight (through the fim cycle)
//               db_estado        - debug state code
// Revision    : 1.0 - initial release
// ============================================================================
module transmissor_quadro_serial
  import transmissor_pkg::*;
#(
  parameter int         CICLOS_POR_BIT = 434,
  parameter logic [7:0] TERMINADOR     = TERMINADOR_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        envia_dados,
  input  logic [7:0]  tela_renderizada,
  input  logic [15:0] pontuacao,
  output logic        saida_serial,
  output logic        fim_envia_dados,
  output logic        ocupado,
  output logic [3:0]  db_estado
);

  localparam logic [IDX_W-1:0] ULTIMO_BYTE = IDX_W'(BYTES_QUADRO - 1);

  estado_t          r_estado;
  estado_t          w_estado_prox;
  logic [7:0]       r_quadro [BYTES_QUADRO];
  logic [IDX_W-1:0] r_byte_idx;
  logic [IDX_W-1:0] w_byte_seg;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_prox;
  logic             r_saida;
  logic             w_saida_prox;
  logic             w_tick;
  logic             w_zera;

  gerador_tick_baud #(
    .CICLOS_POR_BIT (CICLOS_POR_BIT)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .zera  (w_zera),
    .tick  (w_tick)
  );

  assign w_byte_seg = r_byte_idx + IDX_W'(1);

  always_comb begin
    w_estado_prox = r_estado;
    case (r_estado)
      ST_OCIOSO:    if (envia_dados) w_estado_prox = ST_START;
      ST_START:     if (w_tick) w_estado_prox = ST_DADOS;
      ST_DADOS:     if (w_tick && (r_bit_idx == 3'd7)) w_estado_prox = ST_STOP;
      ST_STOP:      if (w_tick) w_estado_prox = ST_PROX_BYTE;
      ST_PROX_BYTE: w_estado_prox = (r_byte_idx == ULTIMO_BYTE) ? ST_FIM : ST_START;
      ST_FIM:       w_estado_prox = ST_OCIOSO;
      ST_ERRO:      w_estado_prox = ST_ERRO;
      default:      w_estado_prox = ST_ERRO;
    endcase

    // Every state entry starts a fresh bit period; idle keeps the timer parked.
    w_zera = (w_estado_prox != r_estado) || (r_estado == ST_OCIOSO);

    w_shift_prox = r_shift;
    if ((r_estado == ST_OCIOSO) && envia_dados) begin
      w_shift_prox = tela_renderizada;
    end else if ((r_estado == ST_DADOS) && w_tick) begin
      w_shift_prox = {1'b0, r_shift[7:1]};
    end else if ((r_estado == ST_PROX_BYTE) && (w_estado_prox == ST_START)) begin
      w_shift_prox = r_quadro[w_byte_seg];
    end

    // Line level is decided from the next state so the registered output
    // changes on the same edge as the state it belongs to.
    case (w_estado_prox)
      ST_START: w_saida_prox = 1'b0;
      ST_DADOS: w_saida_prox = w_shift_prox[0];
      default:  w_saida_prox = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= ST_OCIOSO;
      r_saida    <= 1'b1;
      r_shift    <= '0;
      r_byte_idx <= '0;
      r_bit_idx  <= '0;
      for (int i = 0; i < BYTES_QUADRO; i++) r_quadro[i] <= '0;
    end else begin
      r_estado <= w_estado_prox;
      r_saida  <= w_saida_prox;
      r_shift  <= w_shift_prox;
      case (r_estado)
        ST_OCIOSO: begin
          if (envia_dados) begin
            r_quadro[0] <= tela_renderizada;
            r_quadro[1] <= pontuacao[15:8];
            r_quadro[2] <= pontuacao[7:0];
`ifdef ENVIA_CHECKSUM_EN
            r_quadro[3] <= tela_renderizada ^ pontuacao[15:8] ^ pontuacao[7:0];
            r_quadro[4] <= TERMINADOR;
`else
            r_quadro[3] <= TERMINADOR;
`endif
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
          end
        end
        ST_DADOS: begin
          // Wraps back to 0 after bit 7, ready for the next byte.
          if (w_tick) r_bit_idx <= r_bit_idx + 3'd1;
        end
        ST_PROX_BYTE: begin
          if (r_byte_idx != ULTIMO_BYTE) r_byte_idx <= w_byte_seg;
        end
        default: ;
      endcase
    end
  end

  assign saida_serial    = r_saida;
  assign fim_envia_dados = (r_estado == ST_FIM);
  assign ocupado         = (r_estado != ST_OCIOSO);
  assign db_estado       = r_estado;

endmodule
`default_nettype wire

// File: doc/transmissor_quadro_serial.md
Name: transmissor_quadro_serial

Overview:
Downstream of the menu control unit. On each `envia_dados` pulse it captures the screen code `tela_renderizada` and the current score, then serializes one fixed frame over a UART line (8N1, LSB first) to the Python renderer. It returns `fim_envia_dados` as a one-cycle pulse, which releases the control unit from its wait states.

Parameters:
CICLOS_POR_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range ≥2.
TERMINADOR, 8'h0A, last byte of every frame.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
envia_dados  in  1  start request, one-cycle pulse from the menu UC
tela_renderizada  in  8  screen code, sampled with envia_dados
pontuacao  in  16  current score, sampled with envia_dados
saida_serial  out  1  UART TX line; idles high
fim_envia_dados  out  1  one-cycle pulse when the frame has been fully sent
ocupado  out  1  high from the cycle after acceptance until the fim cycle, inclusive
db_estado  out  4  debug state code

Behaviour:
- Reset is synchronous and active-high, on `clock`. Reset values: state=ocioso, saida_serial=1, fim_envia_dados=0, ocupado=0, db_estado=0, counters=0.
- Frame order: byte0=tela, byte1=pontuacao[15:8], byte2=pontuacao[7:0], byte3=TERMINADOR. That is 4 bytes, 40 bits.
- Each byte is sent as: start bit 0, data bits d0..d7, stop bit 1. Every bit holds for exactly CICLOS_POR_BIT cycles.
- States and db_estado codes: ocioso(0), start(1), dados(2), stop(3), prox_byte(4), fim(5), erro(F).
- ocioso:
  - envia_dados=1 latches tela and pontuacao into frame registers, clears byte_idx and bit_idx, and moves to start.
  - Otherwise remain in ocioso.
- start: saida_serial=0. After CICLOS_POR_BIT cycles, go to dados.
- dados: saida_serial = shift register LSB. Shift every CICLOS_POR_BIT cycles. After the 8th bit, go to stop.
- stop: saida_serial=1. After CICLOS_POR_BIT cycles, go to prox_byte.
- prox_byte: single cycle, saida_serial=1.
  - If byte_idx = last byte, go to fim.
  - Else increment byte_idx, load the next byte, go to start.
- fim: single cycle, fim_envia_dados=1, saida_serial=1, then ocioso.
- Timing: envia_dados sampled at edge t → start bit visible from cycle t+1.
  - fim_envia_dados asserted in cycle t+1+40·CICLOS_POR_BIT+4 (40 bit periods plus 4 single-cycle prox_byte gaps).
  - Each inter-byte gap is therefore a stop bit stretched by 1 cycle.
- saida_serial is driven from a register; it must be glitch-free.
- envia_dados received while ocupado=1 is ignored: no re-latch, no restart.
- Changes on tela/pontuacao after acceptance have no effect on the frame in flight.
- Reset mid-frame: next cycle returns to ocioso with saida_serial=1 and no fim pulse.
- envia_dados in the same cycle as the fim state is ignored. A request in the following cycle (ocioso) is accepted.
- Unreachable state encodings go to erro: saida_serial=1, remain there until reset.

Optional Feature:
ENVIA_CHECKSUM_EN
- Defined: a checksum byte (XOR of byte0..byte2) is inserted before TERMINADOR. The frame becomes 5 bytes / 50 bits, and fim moves to t+1+50·CICLOS_POR_BIT+5.
- Undefined: 4-byte frame as above; no checksum logic synthesized.

Decomposition:
- Package `transmissor_pkg`:
  - state encodings
  - TERMINADOR default
  - BYTES_QUADRO (4, or 5 with checksum)
  - db_estado code constants
- Sub-module `gerador_tick_baud`:
  - counter 0..CICLOS_POR_BIT-1
  - `tick` pulse on terminal count
  - synchronous `zera` input asserted by the FSM on every state entry

Test Plan (CICLOS_POR_BIT=4 on bench):
1. Reset, idle 20 cycles → saida_serial=1, fim_envia_dados=0, ocupado=0, db_estado=0.
2. envia_dados with tela=8'hF4, pontuacao=16'h1234 → line decodes bytes F4,12,34,0A, LSB first; fim pulse exactly 1 cycle at t+165.
3. Second envia_dados at t+50 with tela=8'hF0 → ignored; frame still F4,12,34,0A; single fim pulse.
4. Change tela to 8'hF2 at t+10 → transmitted byte0 remains F4.
5. Reset asserted at t+70 → saida_serial=1 next cycle, db_estado=0, no fim pulse; new request with tela=8'hF1, pontuacao=0 sends F1,00,00,0A.
6. ENVIA_CHECKSUM_EN defined, tela=8'hF3, pontuacao=16'h00FF → bytes F3,00,FF,0C,0A; fim at t+206.
